// File: rtl/pc_pkg.sv
// pc_pkg: shared defaults and next-PC select encoding for the fetch-stage PC sequencer.
package pc_pkg;
  localparam int          PC_ADDR_W       = 32;
  localparam int          PC_INC          = 4;
  localparam int          PC_RESET_VECTOR = -4;
  localparam logic [31:0] PC_EXC_VECTOR   = 32'h0000_0100;
  localparam int          PC_RAS_DEPTH    = 4;
  typedef enum logic [2:0] {SEL_RST, SEL_EXC, SEL_HOLD, SEL_BR, SEL_RET, SEL_SEQ} pc_sel_e;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control inputs and PC/RAS status outputs between fetch control and the PC sequencer.
interface pc_sequencer_if import pc_pkg::*; #(parameter int ADDR_W = PC_ADDR_W);
  logic              BUSYWAIT;
  logic              EXC;
  logic              BRANCH_TAKEN;
  logic [ADDR_W-1:0] BRANCH_TARGET;
  logic              IS_CALL;
  logic              IS_RET;
  logic [ADDR_W-1:0] OUT;
  logic              RAS_EMPTY;
  logic              RAS_FULL;
  logic              RAS_UNDERFLOW;
  modport master (
    output BUSYWAIT, EXC, BRANCH_TAKEN, BRANCH_TARGET, IS_CALL, IS_RET,
    input  OUT, RAS_EMPTY, RAS_FULL, RAS_UNDERFLOW
  );
  modport slave (
    input  BUSYWAIT, EXC, BRANCH_TAKEN, BRANCH_TARGET, IS_CALL, IS_RET,
    output OUT, RAS_EMPTY, RAS_FULL, RAS_UNDERFLOW
  );
endinterface

// File: rtl/pc_sequencer_ras.sv
// ras_stack: circular return-address stack; a push when full overwrites the oldest entry.
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] top_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d, inc_ptr, dec_ptr;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    inc_ptr = ptr_q == PW'(DEPTH - 1) ? '0 : ptr_q + 1'b1;
    dec_ptr = ptr_q == '0 ? PW'(DEPTH - 1) : ptr_q - 1'b1;
    full_o  = cnt_q == CW'(DEPTH);
    empty_o = cnt_q == '0;
    top_o   = mem_q[dec_ptr];
    ptr_d   = flush_i ? '0 : push_i ? inc_ptr : (pop_i && !empty_o) ? dec_ptr : ptr_q;
    cnt_d   = flush_i ? '0 : push_i ? (full_o ? cnt_q : cnt_q + 1'b1)
            : (pop_i && !empty_o) ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge CLK)
    if (!RESET && push_i && !flush_i) mem_q[ptr_q] <= din_i;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage PC register with prioritised next-PC select and a return-address stack.
module pc_sequencer import pc_pkg::*; #(
  parameter int                ADDR_W       = PC_ADDR_W,
  parameter int                INC          = PC_INC,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(PC_RESET_VECTOR),
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(PC_EXC_VECTOR),
  parameter int                RAS_DEPTH    = PC_RAS_DEPTH
) (
  input logic           CLK,
  input logic           RESET,
  pc_sequencer_if.slave bus
);
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, ras_top;
  logic              uf_q, uf_d, ras_full, ras_empty;
  pc_sel_e           sel;
  always_comb begin
    pc_inc = pc_q + ADDR_W'(INC);
    sel    = RESET ? SEL_RST : bus.EXC ? SEL_EXC : bus.BUSYWAIT ? SEL_HOLD
           : bus.BRANCH_TAKEN ? SEL_BR : (bus.IS_RET && !ras_empty) ? SEL_RET : SEL_SEQ;
    pc_d   = sel == SEL_RST  ? RESET_VECTOR
           : sel == SEL_EXC  ? EXC_VECTOR
           : sel == SEL_HOLD ? pc_q
           : sel == SEL_BR   ? bus.BRANCH_TARGET
           : sel == SEL_RET  ? ras_top : pc_inc;
    // A return that reaches the sequential path can only mean the stack was empty.
    uf_d   = sel == SEL_SEQ && bus.IS_RET;
  end
  always_ff @(posedge CLK) begin
    pc_q <= pc_d;
    uf_q <= uf_d;
  end
  ras_stack #(.DEPTH(RAS_DEPTH), .W(ADDR_W)) u_ras (
    .CLK     (CLK),
    .RESET   (RESET),
    .push_i  (sel == SEL_BR && bus.IS_CALL),
    .pop_i   (sel == SEL_RET),
    .flush_i (sel == SEL_EXC),
    .din_i   (pc_inc),
    .top_o   (ras_top),
    .full_o  (ras_full),
    .empty_o (ras_empty)
  );
  assign bus.OUT           = pc_q;
  assign bus.RAS_EMPTY     = ras_empty;
  assign bus.RAS_FULL      = ras_full;
  assign bus.RAS_UNDERFLOW = uf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench; a queue-based reference model predicts PC and RAS flags each cycle.
module tb_pc_sequencer;
  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        e, f, u;
  } exp_t;
  logic CLK = 1'b0, RESET = 1'b1, rst16 = 1'b1;
  int   n_tests = 0, n_fail = 0;
  exp_t sb[$];
  logic [31:0] m_pc = 32'hFFFF_FFFC;
  logic [31:0] m_ras[$];
  logic        m_uf = 1'b0;
  pc_sequencer_if #(.ADDR_W(32)) bus ();
  pc_sequencer_if #(.ADDR_W(16)) b16 ();
  pc_sequencer dut (.CLK(CLK), .RESET(RESET), .bus(bus));
  pc_sequencer #(.ADDR_W(16)) dut16 (.CLK(CLK), .RESET(rst16), .bus(b16));
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step(input string tag, input logic rst, exc, bw, br,
                      input logic [31:0] tgt, input logic call, ret);
    exp_t e;
    @(negedge CLK);
    RESET = rst; bus.EXC = exc; bus.BUSYWAIT = bw; bus.BRANCH_TAKEN = br;
    bus.BRANCH_TARGET = tgt; bus.IS_CALL = call; bus.IS_RET = ret;
    if (rst) begin
      m_pc = 32'hFFFF_FFFC; m_ras.delete(); m_uf = 1'b0;
    end else if (exc) begin
      m_pc = 32'h100; m_ras.delete(); m_uf = 1'b0;
    end else if (bw) begin
      m_uf = 1'b0;
    end else if (br) begin
      if (call) begin
        m_ras.push_back(m_pc + 32'd4);
        if (m_ras.size() > 4) m_ras.delete(0);
      end
      m_pc = tgt; m_uf = 1'b0;
    end else if (ret && m_ras.size() > 0) begin
      m_pc = m_ras.pop_back(); m_uf = 1'b0;
    end else begin
      m_uf = ret; m_pc = m_pc + 32'd4;
    end
    sb.push_back('{tag, m_pc, m_ras.size() == 0, m_ras.size() == 4, m_uf});
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    check({e.tag, ".out"}, bus.OUT, e.pc);
    check({e.tag, ".empty"}, {31'd0, bus.RAS_EMPTY}, {31'd0, e.e});
    check({e.tag, ".full"}, {31'd0, bus.RAS_FULL}, {31'd0, e.f});
    check({e.tag, ".uf"}, {31'd0, bus.RAS_UNDERFLOW}, {31'd0, e.u});
  endtask
  initial begin
    bus.EXC = 0; bus.BUSYWAIT = 0; bus.BRANCH_TAKEN = 0; bus.BRANCH_TARGET = 0;
    bus.IS_CALL = 0; bus.IS_RET = 0;
    b16.EXC = 0; b16.BUSYWAIT = 0; b16.BRANCH_TAKEN = 0; b16.BRANCH_TARGET = 0;
    b16.IS_CALL = 0; b16.IS_RET = 0;
    step("rst0", 1, 0, 0, 0, 0, 0, 0);
    step("rst1", 1, 0, 0, 0, 0, 0, 0);
    check("rst_vec", bus.OUT, 32'hFFFF_FFFC);
    step("first", 0, 0, 0, 0, 0, 0, 0);
    check("first_pc", bus.OUT, 32'h0);
    step("second", 0, 0, 0, 0, 0, 0, 0);
    check("second_pc", bus.OUT, 32'h4);
    step("br10", 0, 0, 0, 1, 32'h10, 0, 0);
    for (int i = 0; i < 3; i++) step("stall", 0, 0, 1, 1, 32'h40, 1, 0);
    check("stall_hold", bus.OUT, 32'h10);
    step("br40", 0, 0, 0, 1, 32'h40, 0, 0);
    step("br20", 0, 0, 0, 1, 32'h20, 0, 0);
    step("call80", 0, 0, 0, 1, 32'h80, 1, 0);
    step("seq84", 0, 0, 0, 0, 0, 0, 0);
    step("ret", 0, 0, 0, 0, 0, 0, 1);
    check("ret_addr", bus.OUT, 32'h24);
    step("call_nobr", 0, 0, 0, 0, 32'h999, 1, 0);
    for (int i = 0; i < 5; i++) step("ncall", 0, 0, 0, 1, 32'h200 + 32'(i) * 32'h100, 1, 0);
    for (int i = 0; i < 5; i++) step("nret", 0, 0, 0, 0, 0, 0, 1);
    check("uf_pc", bus.OUT, 32'h208);
    check("uf_pulse", {31'd0, bus.RAS_UNDERFLOW}, 32'd1);
    step("post_uf", 0, 0, 0, 0, 0, 0, 0);
    step("c1", 0, 0, 0, 1, 32'h700, 1, 0);
    step("c2", 0, 0, 0, 1, 32'h800, 1, 1);
    step("exc_bw", 0, 1, 1, 1, 32'h900, 1, 1);
    check("exc_vec", bus.OUT, 32'h100);
    step("c3", 0, 0, 0, 1, 32'h500, 1, 0);
    step("rst_stall", 1, 0, 1, 1, 32'hA00, 1, 0);
    step("rst_call", 1, 0, 0, 1, 32'hB00, 1, 0);
    step("restart", 0, 0, 0, 0, 0, 0, 0);
    step("brwrap", 0, 0, 0, 1, 32'hFFFF_FFF8, 0, 0);
    step("wrap0", 0, 0, 0, 0, 0, 0, 0);
    step("wrap1", 0, 0, 0, 0, 0, 0, 0);
    check("wrap_zero", bus.OUT, 32'h0);
    check("w16_rst", {16'd0, b16.OUT}, 32'hFFFC);
    @(negedge CLK); rst16 = 0;
    @(posedge CLK); #1 check("w16_first", {16'd0, b16.OUT}, 32'h0);
    @(negedge CLK); b16.BRANCH_TAKEN = 1; b16.BRANCH_TARGET = 16'hFFF8;
    @(posedge CLK); #1 check("w16_br", {16'd0, b16.OUT}, 32'hFFF8);
    @(negedge CLK); b16.BRANCH_TAKEN = 0;
    @(posedge CLK); #1 check("w16_seq", {16'd0, b16.OUT}, 32'hFFFC);
    @(posedge CLK); #1 check("w16_wrap", {16'd0, b16.OUT}, 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
